// File: rtl/hms_counter_param.sv
// Hours/minutes/seconds time-of-day counter with a programmable one-second prescaler,
// validated load/ack/err protocol, 12/24-hour display and alarm-match pulse.
module hms_counter_param #(
    parameter int unsigned CLK_DIV = 100_000_000,
    parameter int unsigned W       = 8
) (
    input  logic         CLK100MHZ,
    input  logic         reset,
    input  logic         enable,
    input  logic         load,
    input  logic [W-1:0] newHours,
    input  logic [W-1:0] newMinutes,
    input  logic [W-1:0] newSeconds,
    input  logic         mode_12h,
    input  logic         alarm_en,
    input  logic [W-1:0] alarm_hours,
    input  logic [W-1:0] alarm_minutes,
    input  logic [W-1:0] alarm_seconds,
    output logic [W-1:0] hours,
    output logic [W-1:0] minutes,
    output logic [W-1:0] seconds,
    output logic         pm,
    output logic         tick,
    output logic         load_ack,
    output logic         load_err,
    output logic         alarm
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] r_pre;
    logic [4:0]    r_h;
    logic [5:0]    r_m;
    logic [5:0]    r_s;
    logic          r_tick;
    logic          r_ack;
    logic          r_err;
    logic          r_alarm;

    logic          w_tick_evt;
    logic          w_load_ok;
    logic          w_s_wrap;
    logic          w_m_wrap;
    logic [4:0]    w_h_nxt;
    logic [5:0]    w_m_nxt;
    logic [5:0]    w_s_nxt;
    logic          w_alarm_hit;
    logic [4:0]    w_h_mod;

    assign w_tick_evt = enable && (r_pre == PRE_MAX);
    assign w_load_ok  = (newHours < W'(24)) && (newMinutes < W'(60)) && (newSeconds < W'(60));

    // Time one second after the current one, with cascaded carries.
    always_comb begin
        w_s_wrap = (r_s == 6'd59);
        w_m_wrap = (r_m == 6'd59);
        w_s_nxt  = w_s_wrap ? 6'd0 : r_s + 6'd1;
        w_m_nxt  = r_m;
        w_h_nxt  = r_h;
        if (w_s_wrap) begin
            w_m_nxt = w_m_wrap ? 6'd0 : r_m + 6'd1;
            if (w_m_wrap) begin
                w_h_nxt = (r_h == 5'd23) ? 5'd0 : r_h + 5'd1;
            end
        end
    end

    // Full-width compare, so out-of-range alarm fields can never match.
    assign w_alarm_hit = alarm_en
                      && (alarm_hours   == W'(w_h_nxt))
                      && (alarm_minutes == W'(w_m_nxt))
                      && (alarm_seconds == W'(w_s_nxt));

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            r_pre   <= '0;
            r_h     <= 5'd0;
            r_m     <= 6'd0;
            r_s     <= 6'd0;
            r_tick  <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_alarm <= 1'b0;
        end else begin
            r_tick  <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_alarm <= 1'b0;
            // A load in the same cycle as a tick event wins; the tick is discarded.
            if (load) begin
                if (w_load_ok) begin
                    r_h   <= newHours[4:0];
                    r_m   <= newMinutes[5:0];
                    r_s   <= newSeconds[5:0];
                    r_pre <= '0;
                    r_ack <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end else if (enable) begin
                r_pre <= w_tick_evt ? '0 : r_pre + PW'(1);
                if (w_tick_evt) begin
                    r_h     <= w_h_nxt;
                    r_m     <= w_m_nxt;
                    r_s     <= w_s_nxt;
                    r_tick  <= 1'b1;
                    r_alarm <= w_alarm_hit;
                end
            end
        end
    end

    // Display formatting follows mode_12h without a register stage.
    always_comb begin
        w_h_mod = (r_h >= 5'd12) ? r_h - 5'd12 : r_h;
        hours   = W'(r_h);
        if (mode_12h) begin
            hours = (w_h_mod == 5'd0) ? W'(12) : W'(w_h_mod);
        end
    end

    assign pm       = (r_h >= 5'd12);
    assign minutes  = W'(r_m);
    assign seconds  = W'(r_s);
    assign tick     = r_tick;
    assign load_ack = r_ack;
    assign load_err = r_err;
    assign alarm    = r_alarm;

endmodule

// File: tb/tb_hms_counter_param.sv
// Bench for hms_counter_param: two instances (CLK_DIV=4 and CLK_DIV=1) share stimulus and
// are compared every cycle against a seconds-of-day model, plus directed literal checks.
module tb_hms_counter_param;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset, enable, load, mode_12h, alarm_en;
    logic [W-1:0] nh, nm, ns, ah, am, as;

    logic [W-1:0] o_h [2];
    logic [W-1:0] o_m [2];
    logic [W-1:0] o_s [2];
    logic         o_pm [2];
    logic         o_tk [2];
    logic         o_ack [2];
    logic         o_err [2];
    logic         o_al [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hms_counter_param #(.CLK_DIV(4), .W(W)) u_div4 (
        .CLK100MHZ(clk), .reset(reset), .enable(enable), .load(load),
        .newHours(nh), .newMinutes(nm), .newSeconds(ns),
        .mode_12h(mode_12h), .alarm_en(alarm_en),
        .alarm_hours(ah), .alarm_minutes(am), .alarm_seconds(as),
        .hours(o_h[0]), .minutes(o_m[0]), .seconds(o_s[0]), .pm(o_pm[0]),
        .tick(o_tk[0]), .load_ack(o_ack[0]), .load_err(o_err[0]), .alarm(o_al[0])
    );

    hms_counter_param #(.CLK_DIV(1), .W(W)) u_div1 (
        .CLK100MHZ(clk), .reset(reset), .enable(enable), .load(load),
        .newHours(nh), .newMinutes(nm), .newSeconds(ns),
        .mode_12h(mode_12h), .alarm_en(alarm_en),
        .alarm_hours(ah), .alarm_minutes(am), .alarm_seconds(as),
        .hours(o_h[1]), .minutes(o_m[1]), .seconds(o_s[1]), .pm(o_pm[1]),
        .tick(o_tk[1]), .load_ack(o_ack[1]), .load_err(o_err[1]), .alarm(o_al[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: time as seconds-of-day, prescaler as enabled cycles since the last tick.
    int div [2] = '{4, 1};
    int t [2];
    int cnt [2];
    bit m_tick [2];
    bit m_ack [2];
    bit m_err [2];
    bit m_al [2];

    task automatic model_step(input int i);
        m_tick[i] = 0; m_ack[i] = 0; m_err[i] = 0; m_al[i] = 0;
        if (!reset) begin
            t[i] = 0; cnt[i] = 0;
        end else if (load) begin
            if (nh < 24 && nm < 60 && ns < 60) begin
                t[i] = int'(nh) * 3600 + int'(nm) * 60 + int'(ns);
                cnt[i] = 0;
                m_ack[i] = 1;
            end else begin
                m_err[i] = 1;
            end
        end else if (enable) begin
            cnt[i]++;
            if (cnt[i] == div[i]) begin
                cnt[i] = 0;
                t[i] = (t[i] + 1) % 86400;
                m_tick[i] = 1;
                if (alarm_en && ah < 24 && am < 60 && as < 60 &&
                    t[i] == int'(ah) * 3600 + int'(am) * 60 + int'(as))
                    m_al[i] = 1;
            end
        end
    endtask

    function automatic int disp_hours(input int tod, input logic m12);
        int h24;
        h24 = tod / 3600;
        if (!m12) return h24;
        return (h24 % 12 == 0) ? 12 : h24 % 12;
    endfunction

    // Per-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                string p;
                p = (i == 0) ? "div4" : "div1";
                model_step(i);
                chk({p, " hours"},    32'(o_h[i]),   32'(disp_hours(t[i], mode_12h)));
                chk({p, " minutes"},  32'(o_m[i]),   32'((t[i] / 60) % 60));
                chk({p, " seconds"},  32'(o_s[i]),   32'(t[i] % 60));
                chk({p, " pm"},       32'(o_pm[i]),  32'(t[i] >= 43200));
                chk({p, " tick"},     32'(o_tk[i]),  32'(m_tick[i]));
                chk({p, " load_ack"}, 32'(o_ack[i]), 32'(m_ack[i]));
                chk({p, " load_err"}, 32'(o_err[i]), 32'(m_err[i]));
                chk({p, " alarm"},    32'(o_al[i]),  32'(m_al[i]));
            end
        end
    end

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_load(input int h, input int m, input int s);
        load = 1'b1; nh = W'(h); nm = W'(m); ns = W'(s);
    endtask

    int hlist [6] = '{0, 1, 11, 12, 13, 23};
    int hexp  [6] = '{12, 1, 11, 12, 1, 11};
    int pexp  [6] = '{0, 0, 0, 1, 1, 1};
    int al_cnt;

    initial begin
        reset = 1'b1; enable = 1'b1; load = 1'b0; mode_12h = 1'b1; alarm_en = 1'b0;
        nh = '0; nm = '0; ns = '0; ah = '0; am = '0; as = '0;
        #3 reset = 1'b0;
        #1;
        chk("reset hours12", 32'(o_h[0]), 32'd12);
        chk("reset pm", 32'(o_pm[0]), 32'd0);
        chk("reset seconds", 32'(o_s[0]), 32'd0);
        mode_12h = 1'b0;
        step(2);
        reset = 1'b1;

        // First tick of the div4 instance lands on the 4th edge after release.
        step(3);
        chk("div4 pre-tick seconds", 32'(o_s[0]), 32'd0);
        step(1);
        chk("div4 first tick seconds", 32'(o_s[0]), 32'd1);
        chk("div4 first tick pulse", 32'(o_tk[0]), 32'd1);
        chk("div1 seconds after 4", 32'(o_s[1]), 32'd4);

        step(2);
        enable = 1'b0;
        step(10);
        chk("frozen seconds", 32'(o_s[0]), 32'd1);
        chk("frozen tick", 32'(o_tk[0]), 32'd0);
        enable = 1'b1;
        step(1);
        chk("resume early seconds", 32'(o_s[0]), 32'd1);
        step(1);
        chk("resume seconds", 32'(o_s[0]), 32'd2);
        chk("resume tick", 32'(o_tk[0]), 32'd1);
        chk("div1 resume seconds", 32'(o_s[1]), 32'd8);

        set_load(12, 30, 45);
        step(1);
        chk("load hours", 32'(o_h[0]), 32'd12);
        chk("load minutes", 32'(o_m[0]), 32'd30);
        chk("load seconds", 32'(o_s[0]), 32'd45);
        chk("load ack", 32'(o_ack[0]), 32'd1);
        set_load(24, 0, 0);
        step(1);
        chk("bad hour err", 32'(o_err[0]), 32'd1);
        chk("bad hour keeps hours", 32'(o_h[0]), 32'd12);
        set_load(0, 60, 0);
        step(1);
        chk("bad minute err", 32'(o_err[0]), 32'd1);
        chk("bad minute keeps minutes", 32'(o_m[0]), 32'd30);
        chk("bad minute keeps seconds", 32'(o_s[1]), 32'd45);
        load = 1'b0;

        // Valid load on the cycle the div4 prescaler would wrap.
        step(3);
        set_load(5, 0, 0);
        step(1);
        load = 1'b0;
        chk("collide hours", 32'(o_h[0]), 32'd5);
        chk("collide seconds", 32'(o_s[0]), 32'd0);
        chk("collide tick", 32'(o_tk[0]), 32'd0);
        chk("collide ack", 32'(o_ack[0]), 32'd1);
        step(3);
        chk("post-collide wait", 32'(o_s[0]), 32'd0);
        step(1);
        chk("post-collide seconds", 32'(o_s[0]), 32'd1);
        chk("post-collide tick", 32'(o_tk[0]), 32'd1);

        set_load(23, 59, 58);
        step(1);
        load = 1'b0;
        chk("wrap load seconds", 32'(o_s[1]), 32'd58);
        step(1);
        chk("wrap 59 seconds", 32'(o_s[1]), 32'd59);
        chk("wrap 59 tick", 32'(o_tk[1]), 32'd1);
        chk("wrap 59 pm", 32'(o_pm[1]), 32'd1);
        step(1);
        chk("wrap hours", 32'(o_h[1]), 32'd0);
        chk("wrap minutes", 32'(o_m[1]), 32'd0);
        chk("wrap seconds", 32'(o_s[1]), 32'd0);
        chk("wrap tick", 32'(o_tk[1]), 32'd1);
        chk("wrap pm", 32'(o_pm[1]), 32'd0);

        ah = W'(0); am = W'(0); as = W'(5); alarm_en = 1'b1;
        set_load(0, 0, 0);
        step(1);
        load = 1'b0;
        al_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            if (k == 5) chk("alarm at 00:00:05", 32'(o_al[1]), 32'd1);
            al_cnt += int'(o_al[1]);
        end
        chk("alarm pulse count", 32'(al_cnt), 32'd1);
        set_load(0, 0, 5);
        step(1);
        load = 1'b0;
        chk("alarm on load", 32'(o_al[1]), 32'd0);
        alarm_en = 1'b0;
        set_load(0, 0, 0);
        step(1);
        load = 1'b0;
        al_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            al_cnt += int'(o_al[1]);
        end
        chk("alarm disabled count", 32'(al_cnt), 32'd0);

        enable = 1'b0; mode_12h = 1'b1;
        for (int k = 0; k < 6; k++) begin
            set_load(hlist[k], 15, 0);
            step(1);
            chk("12h hours", 32'(o_h[1]), 32'(hexp[k]));
            chk("12h pm", 32'(o_pm[1]), 32'(pexp[k]));
        end
        enable = 1'b1;
        set_load(13, 0, 0);
        step(1);
        load = 1'b0;
        chk("mode 12h before toggle", 32'(o_h[1]), 32'd1);
        mode_12h = 1'b0;
        #1;
        chk("mode toggle hours", 32'(o_h[1]), 32'd13);
        chk("mode toggle seconds", 32'(o_s[1]), 32'd0);
        step(1);
        chk("after toggle seconds", 32'(o_s[1]), 32'd1);

        // Randomized phase; alarms are aimed a few seconds ahead of the div1 model.
        for (int c = 0; c < 3000; c++) begin
            step(1);
            enable   = ($urandom_range(0, 7) != 0);
            mode_12h = $urandom_range(0, 1);
            load     = ($urandom_range(0, 7) == 0);
            nh = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 25));
            nm = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 61));
            ns = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 61));
            reset = ($urandom_range(0, 499) != 0);
            if (c % 32 == 0) begin
                int ta;
                ta = (t[1] + int'($urandom_range(1, 30))) % 86400;
                alarm_en = ($urandom_range(0, 3) != 0);
                ah = W'(ta / 3600); am = W'((ta / 60) % 60); as = W'(ta % 60);
                if ($urandom_range(0, 7) == 0) ah = W'($urandom_range(24, 255));
            end
        end

        reset = 1'b1; enable = 1'b1; mode_12h = 1'b0; alarm_en = 1'b0;
        set_load(10, 20, 30);
        step(1);
        load = 1'b0;
        step(3);
        reset = 1'b0;
        #1;
        chk("async reset hours", 32'(o_h[0]), 32'd0);
        chk("async reset minutes", 32'(o_m[0]), 32'd0);
        chk("async reset seconds", 32'(o_s[1]), 32'd0);
        chk("async reset tick", 32'(o_tk[1]), 32'd0);
        mode_12h = 1'b1;
        #1;
        chk("async reset hours12", 32'(o_h[1]), 32'd12);
        step(2);
        reset = 1'b1;
        step(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hms_counter_param.md
# hms_counter_param

Parametrised hours/minutes/seconds time-of-day counter: the next generation of the lab clock counter. A programmable prescaler divides CLK100MHZ down to a one-second tick. The block advances a 24-hour time base and accepts validated time loads through a load/ack/err pulse protocol. It also offers 12/24-hour display mode and an alarm-match pulse. It sits between the board clock and the display/ALU logic, which consume `hours`, `minutes` and `seconds`.

## Interface
- `CLK_DIV`, 100_000_000: clock cycles per one-second tick; legal range ≥ 1, where 1 means every cycle is a tick.
- `W`, 8: width of every time field; legal range ≥ 6.
- `CLK100MHZ`  in  1  system clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  1 = time advances on ticks; 0 = prescaler and time frozen.
- `load`  in  1  single-cycle request to load `newHours`/`newMinutes`/`newSeconds`.
- `newHours`, `newMinutes`, `newSeconds`  in  W each  load values (24-hour, binary).
- `mode_12h`  in  1  0 = 24-hour display; 1 = 12-hour display.
- `alarm_en`  in  1  alarm compare enable.
- `alarm_hours`, `alarm_minutes`, `alarm_seconds`  in  W each  alarm time (24-hour).
- `hours`, `minutes`, `seconds`  out  W each  current time; `hours` formatted per `mode_12h`.
- `pm`  out  1  1 when the internal hour is ≥ 12, in both modes.
- `tick`  out  1  one-cycle pulse; time advanced by a tick.
- `load_ack`  out  1  one-cycle pulse; load accepted.
- `load_err`  out  1  one-cycle pulse; load rejected.
- `alarm`  out  1  one-cycle pulse; a tick advanced the time onto the alarm time.

## Operation
- State consists of:
  - prescaler `pre`, 0..CLK_DIV-1;
  - internal hour `h24`, 0..23;
  - `m` and `s`, each 0..59;
  - registered pulse flags.
- Prescaler:
  - When `enable`=1, `pre` increments each cycle; at CLK_DIV-1 it wraps to 0 and raises the internal tick event.
  - When `enable`=0, `pre` holds and no tick event occurs.
- Tick event advances the time:
  - `s`+1; 59 wraps to 0 and carries into `m`.
  - `m` 59 wraps to 0 and carries into `h24`.
  - `h24` 23 wraps to 0.
  - 23:59:59 → 00:00:00.
- Load validation: a load is valid when `newHours`<24, `newMinutes`<60 and `newSeconds`<60, with comparisons done at full width W.
- Valid load:
  - `h24`, `m` and `s` take the new values; `pre` clears to 0.
  - `load_ack` pulses.
  - A load is accepted regardless of `enable`.
- Invalid load: time and `pre` are unchanged and `load_err` pulses.
- Priority: a load in the same cycle as a tick event wins.
  - The tick is discarded and `tick` does not pulse.
  - `pre` clears if the load is valid and holds at its value otherwise.
- Alarm:
  - `alarm` pulses only when a tick event produces a time equal to the alarm fields while `alarm_en`=1.
  - Loading a time equal to the alarm time does not fire `alarm`.
  - Out-of-range alarm fields never match.
- Display:
  - `mode_12h`=0: `hours` = `h24`.
  - `mode_12h`=1: `hours` = 12 when `h24` mod 12 = 0, otherwise `h24` mod 12.
  - `pm` = (`h24` ≥ 12) in both modes.
  - `hours` is combinational from `h24` and `mode_12h`; `mode_12h` may change at any time and takes effect immediately.
- Output widths: the upper W−6 bits of `minutes` and `seconds` and the upper W−5 bits of `hours` are always 0.

## Timing
- Reset (`reset`=0), asynchronous:
  - `pre`=0 and time = 00:00:00.
  - `tick`, `load_ack`, `load_err` and `alarm` = 0.
  - In 12-hour mode, `hours` reads 12 with `pm`=0.
  - Release is synchronous to the next edge; the first tick occurs CLK_DIV enabled cycles after release.
- Tick timing: with `enable` held high, the time advances every CLK_DIV cycles. `tick` is high for exactly the first cycle in which the new time is visible.
- Load latency: `load` sampled high at edge N means the new time is visible after edge N, with `load_ack` (or `load_err`) high in that same cycle.
- `load` held high for k cycles is treated as k independent loads.
- After a valid load, the next tick occurs CLK_DIV enabled cycles later.
- `alarm` is coincident with `tick` in the cycle where the matched time is first visible.
- Reset mid-operation aborts everything immediately; pending pulses are dropped.

## Test plan
- Wrap: CLK_DIV=1, load 23:59:58, run 2 cycles → times 23:59:59 then 00:00:00, `tick` high both cycles, `pm` going 1→0.
- Prescaler and enable: CLK_DIV=4, from reset → `seconds`=1 after the 4th post-reset edge. Drop `enable` for 10 cycles → no change and no `tick`. Re-enable → the next tick arrives after the remaining prescaler count.
- Load validation:
  - Load 12:30:45 → visible next cycle with `load_ack`=1.
  - Load 24:00:00, then 00:60:00 → `load_err`=1 each time, time still 12:30:45.
- Load/tick collision: CLK_DIV=4, assert a valid load 05:00:00 on the cycle `pre`=3 → time 05:00:00, `tick`=0, next tick 4 cycles later giving 05:00:01.
- Alarm: alarm 00:00:05, `alarm_en`=1, CLK_DIV=1 from 00:00:00 → `alarm` pulses exactly once, with the 00:00:05 tick. Loading 00:00:05 directly → no `alarm`. With `alarm_en`=0 → never pulses.
- 12-hour display: `h24` = 0, 1, 11, 12, 13, 23 with `mode_12h`=1 → `hours` = 12, 1, 11, 12, 1, 11 and `pm` = 0, 0, 0, 1, 1, 1. Toggle `mode_12h` mid-run → `hours` changes the same cycle and the time is undisturbed. Assert `reset` low mid-count → outputs zero immediately.
